// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
//   Shared types and helpers for the SHA-256 message padder.
//   - state_e        : padder FSM states
//   - SHA_BLK_WORDS  : 32-bit words per SHA-256 block
//   - SHA_PAD_BYTE   : the single '1' bit terminator, as a byte
//   - byte_mask()    : keeps the left-justified valid bytes of a word
//   - pad_word()     : masks a final word and drops 0x80 after its data
// ---------------------------------------------------------------------------
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,   // collecting message words into the buffer
        ST_EMIT = 2'd1,   // presenting a finished block downstream
        ST_XTRA = 2'd2    // building the trailing length-only block
    } state_e;

    localparam int          SHA_BLK_WORDS = 16;
    localparam logic [7:0]  SHA_PAD_BYTE  = 8'h80;

    // Bytes are left-justified: byte 0 lives in [31:24].
    function automatic logic [31:0] byte_mask(input logic [2:0] nbytes);
        logic [31:0] m;
        case (nbytes)
            3'd0:    m = 32'h0000_0000;
            3'd1:    m = 32'hFF00_0000;
            3'd2:    m = 32'hFFFF_0000;
            3'd3:    m = 32'hFFFF_FF00;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // With fewer than 4 valid bytes the terminator fits in the same word;
    // a full word is returned unchanged and the terminator goes elsewhere.
    function automatic logic [31:0] pad_word(input logic [31:0] data,
                                             input logic [2:0]  nbytes);
        logic [31:0] w;
        w = data & byte_mask(nbytes);
        case (nbytes)
            3'd0:    w[31:24] = SHA_PAD_BYTE;
            3'd1:    w[23:16] = SHA_PAD_BYTE;
            3'd2:    w[15:8]  = SHA_PAD_BYTE;
            3'd3:    w[7:0]   = SHA_PAD_BYTE;
            default: w        = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sha256_padder.sv
// ---------------------------------------------------------------------------
// sha256_padder
//   Turns a stream of 32-bit big-endian message words into SHA-256 padded
//   512-bit blocks (0x80 terminator, zero fill, 64-bit bit length), one block
//   at a time over a valid/ready handshake.
//
//   clk        in   clock, all logic on rising edge
//   reset      in   synchronous active-high reset, clears all state
//   in_valid   in   input word valid
//   in_ready   out  padder accepts a word this cycle (only in ST_FILL)
//   in_data    in   message word, first byte in [31:24]
//   in_nbytes  in   valid bytes (left-justified); 0..4 only with in_last
//   in_last    in   final word of the message
//   blk_valid  out  blk_data holds a complete block
//   blk_ready  in   consumer takes the block
//   blk_data   out  padded block, word i at [32*i+31:32*i]
//   blk_last   out  final block of the message (carries the length)
// ---------------------------------------------------------------------------
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W     = 64,
    parameter int BLK_WORDS = SHA_BLK_WORDS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_data,
    input  logic [2:0]             in_nbytes,
    input  logic                   in_last,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic [32*BLK_WORDS-1:0] blk_data,
    output logic                   blk_last
);

    localparam int IDX_W = $clog2(BLK_WORDS);
    // Highest pad position that still leaves room for the two length words.
    localparam int LEN_FIT_MAX = BLK_WORDS - 3;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [LEN_W-1:0]   len_q;
    logic [31:0]        buf_q [BLK_WORDS];
    logic               blk_valid_q;
    logic               blk_last_q;
    logic               pend_xtra_q;
    logic               pend_80_q;

    logic [2:0]         nb_eff;
    logic [LEN_W-1:0]   len_d;
    logic [63:0]        len_d64;
    logic [63:0]        len_q64;
    int                 pad_pos;
    logic [31:0]        last_blk_d [BLK_WORDS];
    logic [31:0]        xtra_blk_d [BLK_WORDS];

    // Anything other than a short final word counts as a full word.
    always_comb begin
        nb_eff  = (in_last && (in_nbytes < 3'd4)) ? in_nbytes : 3'd4;
        len_d   = len_q + LEN_W'({nb_eff, 3'b000});
        len_d64 = 64'(len_d);
        len_q64 = 64'(len_q);
        // A full final word pushes the terminator into the following word.
        pad_pos = int'(idx_q) + ((nb_eff == 3'd4) ? 1 : 0);

        for (int w = 0; w < BLK_WORDS; w++) begin
            if (w < int'(idx_q)) begin
                last_blk_d[w] = buf_q[w];
            end else if (w == int'(idx_q)) begin
                last_blk_d[w] = pad_word(in_data, nb_eff);
            end else if (w == pad_pos) begin
                last_blk_d[w] = {SHA_PAD_BYTE, 24'h0};
            end else if ((pad_pos <= LEN_FIT_MAX) && (w == BLK_WORDS - 2)) begin
                last_blk_d[w] = len_d64[63:32];
            end else if ((pad_pos <= LEN_FIT_MAX) && (w == BLK_WORDS - 1)) begin
                last_blk_d[w] = len_d64[31:0];
            end else begin
                last_blk_d[w] = 32'h0;
            end
        end

        // Trailing block: optional terminator in word 0, length at the end.
        for (int w = 0; w < BLK_WORDS; w++) begin
            if (w == 0 && pend_80_q) begin
                xtra_blk_d[w] = {SHA_PAD_BYTE, 24'h0};
            end else if (w == BLK_WORDS - 2) begin
                xtra_blk_d[w] = len_q64[63:32];
            end else if (w == BLK_WORDS - 1) begin
                xtra_blk_d[w] = len_q64[31:0];
            end else begin
                xtra_blk_d[w] = 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FILL;
            idx_q       <= '0;
            len_q       <= '0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            pend_xtra_q <= 1'b0;
            pend_80_q   <= 1'b0;
            for (int w = 0; w < BLK_WORDS; w++) begin
                buf_q[w] <= 32'h0;
            end
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (in_valid) begin
                        len_q <= len_d;
                        if (in_last) begin
                            for (int w = 0; w < BLK_WORDS; w++) begin
                                buf_q[w] <= last_blk_d[w];
                            end
                            idx_q       <= '0;
                            state_q     <= ST_EMIT;
                            blk_valid_q <= 1'b1;
                            blk_last_q  <= (pad_pos <= LEN_FIT_MAX);
                            pend_xtra_q <= (pad_pos > LEN_FIT_MAX);
                            pend_80_q   <= (pad_pos == BLK_WORDS);
                        end else begin
                            buf_q[idx_q] <= in_data;
                            if (idx_q == IDX_W'(BLK_WORDS - 1)) begin
                                idx_q       <= '0;
                                state_q     <= ST_EMIT;
                                blk_valid_q <= 1'b1;
                                blk_last_q  <= 1'b0;
                                pend_xtra_q <= 1'b0;
                                pend_80_q   <= 1'b0;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    if (blk_ready) begin
                        blk_valid_q <= 1'b0;
                        if (pend_xtra_q) begin
                            state_q <= ST_XTRA;
                        end else begin
                            state_q <= ST_FILL;
                            if (blk_last_q) begin
                                len_q <= '0;
                                idx_q <= '0;
                            end
                        end
                    end
                end
                ST_XTRA: begin
                    for (int w = 0; w < BLK_WORDS; w++) begin
                        buf_q[w] <= xtra_blk_d[w];
                    end
                    blk_last_q  <= 1'b1;
                    blk_valid_q <= 1'b1;
                    pend_xtra_q <= 1'b0;
                    pend_80_q   <= 1'b0;
                    state_q     <= ST_EMIT;
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    // Held low while reset is asserted so nothing is taken during that cycle.
    assign in_ready  = (state_q == ST_FILL) && !reset;
    assign blk_valid = blk_valid_q;
    assign blk_last  = blk_last_q;

    generate
        for (genvar gi = 0; gi < BLK_WORDS; gi++) begin : g_blk
            assign blk_data[32*gi +: 32] = buf_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sha256_padder.sv
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [2:0]   in_nbytes;
    logic         in_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;

    always #5 clk = ~clk;

    sha256_padder #(.LEN_W(64), .BLK_WORDS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_nbytes (in_nbytes),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    typedef struct {
        int          len;   // message length in bytes
        int          nblk;  // expected block count
        int          kb;    // block holding the hand-checked word
        int          kw;    // word index of the hand-checked word
        logic [31:0] kval;  // its expected value
    } vec_t;

    typedef struct {
        logic [511:0] d;
        logic         l;
    } blk_t;

    vec_t vecs[10];
    blk_t got_q[$];
    int   total = 0;
    int   bad   = 0;
    logic ready_mode   = 1'b0;  // 1: random blk_ready, 0: ready_manual
    logic ready_manual = 1'b1;

    // Every accepted block is captured away from the clock edge.
    always @(negedge clk) begin
        if (!reset && blk_valid && blk_ready) begin
            blk_t b;
            b.d = blk_data;
            b.l = blk_last;
            got_q.push_back(b);
        end
    end

    initial begin
        blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            blk_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_manual;
        end
    end

    function automatic logic [7:0] msg_byte(input int k);
        return 8'(k + 1);
    endfunction

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout got=0 exp=1");
        end
    endtask

    task automatic send_word(input logic [31:0] d, input int nb, input logic last);
        in_data   = d;
        in_nbytes = 3'(nb);
        in_last   = last;
        in_valid  = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Bytes past the message end are filled with 0xEE to exercise masking.
    task automatic send_msg(input int len);
        int nw = (len == 0) ? 1 : (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            int nb;
            nb = len - 4 * w;
            if (nb > 4) nb = 4;
            for (int j = 0; j < 4; j++)
                d[31 - 8*j -: 8] = (j < nb) ? msg_byte(4*w + j) : 8'hEE;
            send_word(d, nb, (w == nw - 1));
        end
    endtask

    task automatic send_raw(input int nwords);
        for (int w = 0; w < nwords; w++) begin
            logic [31:0] d;
            for (int j = 0; j < 4; j++) d[31 - 8*j -: 8] = msg_byte(4*w + j);
            send_word(d, 4, 1'b0);
        end
    endtask

    task automatic wait_done(input int maxcyc);
        int n = 0;
        while (!(got_q.size() > 0 && got_q[got_q.size()-1].l) && n < maxcyc) begin
            @(negedge clk);
            n++;
        end
        chk("msg_complete", 512'(got_q.size() > 0 && got_q[got_q.size()-1].l), 512'(1));
    endtask

    // Reference: FIPS 180-4 padding done bytewise, then sliced into blocks.
    task automatic check_msg(input vec_t v);
        logic [7:0]  b[$];
        logic [63:0] bl;
        int          exp_n;
        int          n;
        for (int k = 0; k < v.len; k++) b.push_back(msg_byte(k));
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        bl = 64'(v.len) * 64'd8;
        for (int j = 0; j < 8; j++) b.push_back(bl[63 - 8*j -: 8]);
        exp_n = b.size() / 64;
        chk("block_count", 512'(got_q.size()), 512'(v.nblk));
        chk("model_count", 512'(exp_n), 512'(v.nblk));
        n = (got_q.size() < exp_n) ? got_q.size() : exp_n;
        for (int j = 0; j < n; j++) begin
            logic [511:0] e;
            for (int i = 0; i < 16; i++)
                e[32*i +: 32] = {b[64*j + 4*i], b[64*j + 4*i + 1],
                                 b[64*j + 4*i + 2], b[64*j + 4*i + 3]};
            chk($sformatf("len%0d_blk%0d_data", v.len, j), got_q[j].d, e);
            chk($sformatf("len%0d_blk%0d_last", v.len, j), 512'(got_q[j].l),
                512'(j == exp_n - 1));
        end
        if (v.kb < got_q.size())
            chk($sformatf("len%0d_key_word", v.len), 512'(got_q[v.kb].d[32*v.kw +: 32]),
                512'(v.kval));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_during_reset", 512'(in_ready), 512'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("blk_valid_after_reset", 512'(blk_valid), 512'(0));
        chk("blk_data_after_reset", blk_data, 512'(0));
        chk("in_ready_after_reset", 512'(in_ready), 512'(1));
    endtask

    task automatic check_abc();
        logic [511:0] e;
        got_q.delete();
        send_word(32'h616263EE, 3, 1'b1);
        wait_done(50);
        e = '0;
        e[31:0]    = 32'h61626380;
        e[511:480] = 32'h00000018;
        chk("abc_count", 512'(got_q.size()), 512'(1));
        if (got_q.size() > 0) begin
            chk("abc_data", got_q[0].d, e);
            chk("abc_last", 512'(got_q[0].l), 512'(1));
        end
        $display("msg abc blocks=%0d", got_q.size());
    endtask

    initial begin
        logic [511:0] snap;

        vecs[0] = '{0,   1, 0, 0,  32'h80000000};
        vecs[1] = '{1,   1, 0, 0,  32'h01800000};
        vecs[2] = '{52,  1, 0, 13, 32'h80000000};
        vecs[3] = '{55,  1, 0, 13, 32'h35363780};
        vecs[4] = '{56,  2, 1, 15, 32'h000001C0};
        vecs[5] = '{60,  2, 0, 15, 32'h80000000};
        vecs[6] = '{62,  2, 0, 15, 32'h3D3E8000};
        vecs[7] = '{64,  2, 1, 0,  32'h80000000};
        vecs[8] = '{70,  2, 1, 1,  32'h45468000};
        vecs[9] = '{128, 3, 2, 15, 32'h00000400};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_nbytes = '0;
        in_last   = 1'b0;

        @(negedge clk);
        chk("reset_in_ready", 512'(in_ready), 512'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_blk_valid", 512'(blk_valid), 512'(0));
        chk("reset_blk_last", 512'(blk_last), 512'(0));
        chk("reset_blk_data", blk_data, 512'(0));
        chk("reset_in_ready_after", 512'(in_ready), 512'(1));

        // Table-driven messages with random consumer backpressure.
        ready_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            got_q.delete();
            @(posedge clk);
            #1;
            send_msg(vecs[i].len);
            wait_done(200);
            check_msg(vecs[i]);
            $display("msg len=%0d blocks=%0d", vecs[i].len, got_q.size());
        end

        // Backpressure: block held for 5 cycles, then reset while emitting.
        ready_mode   = 1'b0;
        ready_manual = 1'b0;
        @(posedge clk);
        #1;
        got_q.delete();
        send_raw(16);
        @(negedge clk);
        chk("bp_blk_valid_rise", 512'(blk_valid), 512'(1));
        chk("bp_word0", 512'(blk_data[31:0]), 512'(32'h01020304));
        snap = blk_data;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_stable_c%0d", c), blk_data, snap);
            chk($sformatf("bp_valid_c%0d", c), 512'(blk_valid), 512'(1));
            chk($sformatf("bp_in_ready_c%0d", c), 512'(in_ready), 512'(0));
        end
        $display("backpressure held 5 cycles");
        pulse_reset();
        ready_manual = 1'b1;
        check_abc();

        // Reset in the middle of filling a block.
        send_raw(3);
        pulse_reset();
        check_abc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
